pe_feeder: RTL and testbench

- Drives the load/start side of one PE's scratchpad protocol: it writes the ifmap and filter scratchpads, starts computation, and waits for `complete`.
- It reads ifmap and filter words from its memory bank ports and streams them into the PE with the required load/load2/load3 qualifiers.
- It then holds `start` until the PE reports `complete`.
- Sits between the global buffer banks and each PE in the PE array; one instance per PE set, under pe_array_control.

---
 rtl/eyeriss_pkg.sv | 24 ++
 rtl/feeder_stream.sv | 45 ++++
 rtl/pe_feeder.sv | 177 +++++++++++++++++
 tb/tb_pe_feeder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/eyeriss_pkg.sv
// Shared types and constants for the Eyeriss PE feeder path.
package eyeriss_pkg;

    localparam int unsigned DATA_W_C      = 16;
    localparam int unsigned IFMAP_DEPTH_C = 12;
    localparam int unsigned FILT_DEPTH_C  = 224;
    localparam int unsigned CNT_W_C       = 12;

    // Nominal configuration ranges of filter_width / oc / ic
    localparam int unsigned FW_MAX_C = 12;
    localparam int unsigned OC_MAX_C = 24;
    localparam int unsigned IC_MAX_C = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_IF = 3'd1,
        ST_GAP1  = 3'd2,
        ST_RD_FL = 3'd3,
        ST_GAP2  = 3'd4,
        ST_RUN   = 3'd5,
        ST_FIN   = 3'd6
    } feeder_state_e;

endpackage

// File: rtl/feeder_stream.sv
// Counter + address generator: issues `count` sequential bank reads from `base` after a kick.
module feeder_stream #(
    parameter int unsigned AW = 4,
    parameter int unsigned CW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          kick,
    input  logic [AW-1:0] base,
    input  logic [CW-1:0] count,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          data_valid,
    output logic          last
);

    logic [CW-1:0] remaining;

    // last marks the cycle in which the final word's read data is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            remaining  <= '0;
            data_valid <= 1'b0;
            last       <= 1'b0;
        end else begin
            data_valid <= rd_en;
            last       <= rd_en && (remaining == '0);
            if (kick) begin
                rd_en     <= 1'b1;
                rd_addr   <= base;
                remaining <= count - CW'(1);
            end else if (rd_en) begin
                if (remaining == '0) begin
                    rd_en <= 1'b0;
                end else begin
                    remaining <= remaining - CW'(1);
                    rd_addr   <= rd_addr + AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Loads one PE's ifmap/filter scratchpads from bank ports, then holds start until complete.
// Optional RUN watchdog enabled by defining PE_FEEDER_TIMEOUT_EN.
module pe_feeder
    import eyeriss_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_C,
    parameter int unsigned IFMAP_DEPTH = IFMAP_DEPTH_C,
    parameter int unsigned FILT_DEPTH  = FILT_DEPTH_C,
    parameter int unsigned IF_AW       = 4,
    parameter int unsigned FL_AW       = 8
`ifdef PE_FEEDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [4:0]        filter_width,
    input  logic [4:0]        oc,
    input  logic [4:0]        ic,
    input  logic [IF_AW-1:0]  if_base,
    input  logic [FL_AW-1:0]  fl_base,
    output logic              if_rd_en,
    output logic [IF_AW-1:0]  if_rd_addr,
    input  logic [DATA_W-1:0] if_rd_data,
    output logic              fl_rd_en,
    output logic [FL_AW-1:0]  fl_rd_addr,
    input  logic [DATA_W-1:0] fl_rd_data,
    output logic [DATA_W-1:0] ifmap,
    output logic [DATA_W-1:0] filt,
    output logic              load,
    output logic              load2,
    output logic              load3,
    output logic              start,
    input  logic              complete,
    output logic              busy,
    output logic              done,
`ifdef PE_FEEDER_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic              cfg_err
);

    localparam int unsigned CNT_W = CNT_W_C;

    feeder_state_e state, next_state;

    logic [CNT_W-1:0] n_if, n_fl, n_fl_q;
    logic [FL_AW-1:0] fl_base_q;
    logic             cfg_ok, if_kick, fl_kick, cfg_reject, if_last, fl_last;

    assign n_if   = CNT_W'(filter_width) * CNT_W'(ic);
    assign n_fl   = n_if * CNT_W'(oc);
    assign cfg_ok = (filter_width != '0) && (oc != '0) && (ic != '0) &&
                    (n_if <= CNT_W'(IFMAP_DEPTH)) && (n_fl <= CNT_W'(FILT_DEPTH));

`ifdef PE_FEEDER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] run_cnt;
    logic            timeout_hit;
`endif

    feeder_stream #(.AW(IF_AW), .CW(CNT_W)) u_if_stream (
        .clk        (clk),
        .reset      (reset),
        .kick       (if_kick),
        .base       (if_base),
        .count      (n_if),
        .rd_en      (if_rd_en),
        .rd_addr    (if_rd_addr),
        .data_valid (load2),
        .last       (if_last)
    );

    feeder_stream #(.AW(FL_AW), .CW(CNT_W)) u_fl_stream (
        .clk        (clk),
        .reset      (reset),
        .kick       (fl_kick),
        .base       (fl_base_q),
        .count      (n_fl_q),
        .rd_en      (fl_rd_en),
        .rd_addr    (fl_rd_addr),
        .data_valid (load3),
        .last       (fl_last)
    );

    // Bank data is only presented to the PE while its qualifier is high
    assign load  = load2 | load3;
    assign ifmap = load2 ? if_rd_data : '0;
    assign filt  = load3 ? fl_rd_data : '0;

    always_comb begin
        next_state = state;
        if_kick    = 1'b0;
        fl_kick    = 1'b0;
        cfg_reject = 1'b0;
`ifdef PE_FEEDER_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (go) begin
                    if (cfg_ok) begin
                        next_state = ST_RD_IF;
                        if_kick    = 1'b1;
                    end else begin
                        cfg_reject = 1'b1;
                    end
                end
            end
            ST_RD_IF: begin
                // Filter reads launch one cycle early so GAP1 is exactly one cycle
                if (if_last) begin
                    next_state = ST_GAP1;
                    fl_kick    = 1'b1;
                end
            end
            ST_GAP1:  next_state = ST_RD_FL;
            ST_RD_FL: if (fl_last) next_state = ST_GAP2;
            ST_GAP2:  next_state = ST_RUN;
            ST_RUN: begin
                if (complete) begin
                    next_state = ST_FIN;
                end
`ifdef PE_FEEDER_TIMEOUT_EN
                else if (run_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    next_state  = ST_FIN;
                    timeout_hit = 1'b1;
                end
`endif
            end
            ST_FIN:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            start     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            n_fl_q    <= '0;
            fl_base_q <= '0;
        end else begin
            state <= next_state;
            start <= (next_state == ST_RUN);
            busy  <= (next_state != ST_IDLE);
            done  <= (next_state == ST_FIN);
            if (cfg_reject) cfg_err <= 1'b1;
            if (if_kick) begin
                n_fl_q    <= n_fl;
                fl_base_q <= fl_base;
            end
        end
    end

`ifdef PE_FEEDER_TIMEOUT_EN
    // RUN watchdog; timeout flag is sticky until reset or the next go
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            run_cnt <= (state == ST_RUN) ? run_cnt + TO_W'(1) : '0;
            if (timeout_hit) begin
                timeout <= 1'b1;
            end else if (state == ST_IDLE && go) begin
                timeout <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Directed self-checking bench for pe_feeder with simple registered bank models.
`timescale 1ns/1ps
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        reset, go, complete;
    logic [4:0]  filter_width, oc, ic;
    logic [3:0]  if_base, if_rd_addr;
    logic [7:0]  fl_base, fl_rd_addr;
    logic        if_rd_en, fl_rd_en;
    logic [15:0] if_rd_data, fl_rd_data, ifmap, filt;
    logic        load, load2, load3, start, busy, done, cfg_err;
`ifdef PE_FEEDER_TIMEOUT_EN
    logic        timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;
    string phase = "init";

    always #5 clk = ~clk;

    // Bank contents: ifmap word = 0x1000+addr, filter word = 0x2000+addr
    always @(posedge clk) begin
        if (if_rd_en) if_rd_data <= 16'h1000 + {12'h000, if_rd_addr};
        if (fl_rd_en) fl_rd_data <= 16'h2000 + {8'h00, fl_rd_addr};
    end

`ifdef PE_FEEDER_TIMEOUT_EN
    pe_feeder #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .go(go), .filter_width(filter_width), .oc(oc), .ic(ic),
        .if_base(if_base), .fl_base(fl_base), .if_rd_en(if_rd_en), .if_rd_addr(if_rd_addr),
        .if_rd_data(if_rd_data), .fl_rd_en(fl_rd_en), .fl_rd_addr(fl_rd_addr),
        .fl_rd_data(fl_rd_data), .ifmap(ifmap), .filt(filt), .load(load), .load2(load2),
        .load3(load3), .start(start), .complete(complete), .busy(busy), .done(done),
        .timeout(timeout), .cfg_err(cfg_err)
    );
`else
    pe_feeder dut (
        .clk(clk), .reset(reset), .go(go), .filter_width(filter_width), .oc(oc), .ic(ic),
        .if_base(if_base), .fl_base(fl_base), .if_rd_en(if_rd_en), .if_rd_addr(if_rd_addr),
        .if_rd_data(if_rd_data), .fl_rd_en(fl_rd_en), .fl_rd_addr(fl_rd_addr),
        .fl_rd_data(fl_rd_data), .ifmap(ifmap), .filt(filt), .load(load), .load2(load2),
        .load3(load3), .start(start), .complete(complete), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
        end
    endtask

    // One load+compute pass. cdly: start cycles before complete (0 = never raise it).
    // poke: complete during RD_IF and go during RUN. rst_at: reset on that filter-load cycle.
    task automatic run_pass(input int fw, input int icn, input int ocn, input int ifb,
                            input int flb, input int cdly, input bit poke, input int rst_at);
        int n_if = fw * icn;
        int n_fl = n_if * ocn;
        int run_len = (cdly > 0) ? cdly : 16;
        int if_k = 0, fl_k = 0, ld2_n = 0, ld3_n = 0, both_n = 0, stray_ld = 0;
        int st_n = 0, done_n = 0, done_cyc = -1, first_ld3 = -1, last_ld2 = -1, after_act = 0;
        @(negedge clk);
        filter_width = 5'(fw); ic = 5'(icn); oc = 5'(ocn);
        if_base = 4'(ifb); fl_base = 8'(flb);
        go = 1'b1;
        for (int cyc = 1; cyc < 600; cyc++) begin
            @(negedge clk);
            go = 1'b0;
            complete = 1'b0;
            if (if_rd_en) begin
                check("if_addr", 32'(if_rd_addr), 32'((ifb + if_k) % 16));
                if_k++;
            end
            if (fl_rd_en) begin
                check("fl_addr", 32'(fl_rd_addr), 32'((flb + fl_k) % 256));
                fl_k++;
            end
            if (load2) begin
                check("ifmap", 32'(ifmap), 32'(16'h1000 + (ifb + ld2_n) % 16));
                ld2_n++;
                last_ld2 = cyc;
            end
            if (load3) begin
                check("filt", 32'(filt), 32'(16'h2000 + (flb + ld3_n) % 256));
                if (ld3_n == 0) first_ld3 = cyc;
                ld3_n++;
            end
            if (load2 && load3) both_n++;
            if (load != (load2 || load3)) stray_ld++;
            if (start) st_n++;
            if (done_n > 0 && (if_rd_en || fl_rd_en || start || busy || load || done)) after_act++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
                check("busy_in_fin", 32'(busy), 32'd1);
            end
            if (rst_at > 0 && load3 && ld3_n == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_load", 32'(load), 32'd0);
                check("rst_load3", 32'(load3), 32'd0);
                check("rst_start", 32'(start), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_fl_rd_en", 32'(fl_rd_en), 32'd0);
                check("rst_cfg_err", 32'(cfg_err), 32'd0);
                return;
            end
            if (poke && cyc == 1) complete = 1'b1;
            if (poke && start && st_n == 5) go = 1'b1;
            if (cdly > 0 && start && st_n == cdly) complete = 1'b1;
            if (done_n > 0 && cyc >= done_cyc + 3) break;
        end
        check("if_reads", 32'(if_k), 32'(n_if));
        check("fl_reads", 32'(fl_k), 32'(n_fl));
        check("load2_cycles", 32'(ld2_n), 32'(n_if));
        check("load3_cycles", 32'(ld3_n), 32'(n_fl));
        check("last_load2", 32'(last_ld2), 32'(n_if + 1));
        check("first_load3", 32'(first_ld3), 32'(n_if + 3));
        check("load2_and_load3", 32'(both_n), 32'd0);
        check("load_qual", 32'(stray_ld), 32'd0);
        check("start_cycles", 32'(st_n), 32'(run_len));
        check("done_pulses", 32'(done_n), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(n_if + n_fl + 4 + run_len));
        check("idle_after_done", 32'(after_act), 32'd0);
    endtask

    // Rejected configuration: no bank or PE activity, cfg_err set
    task automatic run_reject(input int fw, input int icn, input int ocn);
        int act = 0;
        @(negedge clk);
        filter_width = 5'(fw); ic = 5'(icn); oc = 5'(ocn);
        go = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            go = 1'b0;
            if (if_rd_en || fl_rd_en || busy || load || start || done) act++;
        end
        check("reject_activity", 32'(act), 32'd0);
        check("reject_cfg_err", 32'(cfg_err), 32'd1);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; complete = 1'b0;
        filter_width = '0; oc = '0; ic = '0; if_base = '0; fl_base = '0;
        repeat (3) @(negedge clk);
        phase = "reset";
        check("busy", 32'(busy), 32'd0);
        check("done", 32'(done), 32'd0);
        check("start", 32'(start), 32'd0);
        check("load", 32'({load, load2, load3}), 32'd0);
        check("rd_en", 32'({if_rd_en, fl_rd_en}), 32'd0);
        check("cfg_err", 32'(cfg_err), 32'd0);
        // go in the same cycle as reset is dropped by reset
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("go_with_reset", 32'({busy, if_rd_en}), 32'd0);
        reset = 1'b0;

        phase = "basic";
        run_pass(3, 1, 2, 0, 8'h10, 20, 1'b0, 0);
        phase = "poke";
        run_pass(2, 2, 3, 5, 8'h40, 9, 1'b1, 0);
        phase = "fl_wrap";
        run_pass(2, 1, 2, 3, 8'hFE, 4, 1'b0, 0);
        phase = "if_wrap_max";
        run_pass(12, 1, 18, 9, 8'h20, 2, 1'b0, 0);

        phase = "reject_nif";
        run_reject(12, 2, 1);
        phase = "reject_zero";
        run_reject(3, 1, 0);
        phase = "reject_nfl";
        run_reject(12, 1, 19);
        phase = "after_reject";
        run_pass(4, 3, 1, 0, 8'h80, 3, 1'b0, 0);
        check("cfg_err_sticky", 32'(cfg_err), 32'd1);

        phase = "mid_reset";
        run_pass(3, 1, 2, 0, 8'h10, 20, 1'b0, 2);
        phase = "post_reset";
        run_pass(3, 1, 2, 0, 8'h10, 6, 1'b0, 0);

`ifdef PE_FEEDER_TIMEOUT_EN
        phase = "timeout";
        run_pass(1, 1, 1, 2, 8'h30, 0, 1'b0, 0);
        check("timeout_set", 32'(timeout), 32'd1);
        @(negedge clk);
        go = 1'b1; filter_width = 5'd1; ic = 5'd1; oc = 5'd1;
        @(negedge clk);
        go = 1'b0;
        check("timeout_cleared", 32'(timeout), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
